// File: rtl/tdm_demux4.sv
// Four-channel TDM receive demultiplexer: aligns to a per-frame sync marker,
// deserializes four MSB-first slots and presents them together with a strobe.
module tdm_demux4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             sync,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1,
    output logic [WIDTH-1:0] ch2,
    output logic [WIDTH-1:0] ch3,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err,
    output logic [1:0]       slot
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    bit_cnt_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shadow0_r;
    logic [WIDTH-1:0] shadow1_r;
    logic [WIDTH-1:0] shadow2_r;

    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] first_word_s;
    logic             at_start_s;
    logic             last_bit_s;

    // Decode of the current bit position and the word being assembled.
    always_comb begin
        word_s       = {shift_r[WIDTH-2:0], din};
        first_word_s = {{(WIDTH-1){1'b0}}, din};
        if ((bit_cnt_r == {CW{1'b0}}) && (slot == 2'd0)) begin
            at_start_s = 1'b1;
        end else begin
            at_start_s = 1'b0;
        end
        if (bit_cnt_r == CW'(WIDTH - 1)) begin
            last_bit_s = 1'b1;
        end else begin
            last_bit_s = 1'b0;
        end
    end

    // Framing FSM, deserializer, shadow registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= HUNT;
            bit_cnt_r   <= {CW{1'b0}};
            shift_r     <= {WIDTH{1'b0}};
            shadow0_r   <= {WIDTH{1'b0}};
            shadow1_r   <= {WIDTH{1'b0}};
            shadow2_r   <= {WIDTH{1'b0}};
            ch0         <= {WIDTH{1'b0}};
            ch1         <= {WIDTH{1'b0}};
            ch2         <= {WIDTH{1'b0}};
            ch3         <= {WIDTH{1'b0}};
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            slot        <= 2'd0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (en) begin
                case (state_r)
                    HUNT: begin
                        if (sync) begin
                            shift_r   <= first_word_s;
                            bit_cnt_r <= CW'(1);
                            slot      <= 2'd0;
                            state_r   <= RUN;
                            locked    <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (at_start_s && !sync) begin
                            // Missing marker: drop the bit and fall back to hunting.
                            sync_err  <= 1'b1;
                            state_r   <= HUNT;
                            locked    <= 1'b0;
                            bit_cnt_r <= {CW{1'b0}};
                            slot      <= 2'd0;
                            shift_r   <= {WIDTH{1'b0}};
                        end else if (sync && !at_start_s) begin
                            // Marker arrived early: restart the frame on this bit.
                            sync_err  <= 1'b1;
                            shift_r   <= first_word_s;
                            bit_cnt_r <= CW'(1);
                            slot      <= 2'd0;
                        end else if (last_bit_s) begin
                            shift_r   <= word_s;
                            bit_cnt_r <= {CW{1'b0}};
                            slot      <= slot + 2'd1;
                            case (slot)
                                2'd0: shadow0_r <= word_s;
                                2'd1: shadow1_r <= word_s;
                                2'd2: shadow2_r <= word_s;
                                2'd3: begin
                                    ch0         <= shadow0_r;
                                    ch1         <= shadow1_r;
                                    ch2         <= shadow2_r;
                                    ch3         <= word_s;
                                    frame_valid <= 1'b1;
                                end
                                default: shadow0_r <= shadow0_r;
                            endcase
                        end else begin
                            shift_r   <= word_s;
                            bit_cnt_r <= bit_cnt_r + CW'(1);
                        end
                    end
                    default: begin
                        state_r   <= HUNT;
                        locked    <= 1'b0;
                        bit_cnt_r <= {CW{1'b0}};
                        slot      <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomized self-checking bench for tdm_demux4 (WIDTH=4) against a frame-level
// behavioural model that tracks the bit position within a 4*WIDTH-bit frame.
module tb_tdm_demux4;

    localparam int W = 4;
    localparam int FB = 4 * W;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         din;
    logic         sync;
    logic [W-1:0] ch0, ch1, ch2, ch3;
    logic         frame_valid, locked, sync_err;
    logic [1:0]   slot;

    tdm_demux4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
        .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
        .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err), .slot(slot)
    );

    always #5 clk = ~clk;

    // Model: locked flag, position within the frame, and the frame's bits.
    logic         m_locked;
    int           m_pos;
    logic         m_bits [FB];
    logic [W-1:0] m_ch [4];
    logic         m_fv, m_err;
    int           m_en_edges;

    function automatic void m_store(input logic b);
        m_bits[m_pos] = b;
        m_pos = m_pos + 1;
        if (m_pos == FB) begin
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < W; i++)
                    m_ch[k][W-1-i] = m_bits[k*W+i];
            m_fv  = 1'b1;
            m_pos = 0;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_locked = 1'b0; m_pos = 0; m_fv = 1'b0; m_err = 1'b0;
            for (int k = 0; k < 4; k++) m_ch[k] = '0;
        end else begin
            m_fv = 1'b0; m_err = 1'b0;
            if (en) begin
                m_en_edges = m_en_edges + 1;
                if (!m_locked) begin
                    if (sync) begin
                        m_locked = 1'b1; m_pos = 0; m_store(din);
                    end
                end else if (m_pos == 0) begin
                    if (sync) m_store(din);
                    else begin
                        m_err = 1'b1; m_locked = 1'b0;
                    end
                end else if (sync) begin
                    m_err = 1'b1; m_pos = 0; m_store(din);
                end else begin
                    m_store(din);
                end
            end
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    int fv_count = 0;
    int err_count = 0;
    int strobe_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // One enabled/disabled bit period, then the per-cycle model comparison.
    task automatic tick(input logic b, input logic s, input logic e);
        logic [1:0] m_slot;
        din = b; sync = s; en = e;
        @(negedge clk);
        m_slot = m_locked ? 2'(m_pos / W) : 2'd0;
        chk("model", {11'd0, ch0, ch1, ch2, ch3, frame_valid, locked, sync_err, slot},
            {11'd0, m_ch[0], m_ch[1], m_ch[2], m_ch[3], m_fv, m_locked, m_err, m_slot});
        if (frame_valid) begin
            fv_count++;
            strobe_q.push_back(m_en_edges);
        end
        if (sync_err) err_count++;
    endtask

    task automatic send(input logic [15:0] v, input int n, input logic first_sync);
        for (int i = 0; i < n; i++) tick(v[15-i], first_sync && (i == 0), 1'b1);
    endtask

    task automatic chk_ch(input string name, input logic [15:0] exp);
        chk(name, {16'd0, ch0, ch1, ch2, ch3}, {16'd0, exp});
    endtask

    int fv0, err0;
    logic [15:0] data;
    logic s;

    initial begin
        rst = 1'b1; en = 1'b0; din = 1'b0; sync = 1'b0; m_en_edges = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Idle with no marker: never locks, no strobes.
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 1'b1);
        chk("idle_locked", {31'd0, locked}, 32'd0);
        chk("idle_strobes", fv_count + err_count, 32'd0);

        // Single frame A,5,F,3.
        tick(1'b1, 1'b1, 1'b1);
        chk("lock_edge1", {31'd0, locked}, 32'd1);
        send(16'hA5F3 << 1, 15, 1'b0);
        chk("fv_latency", {31'd0, frame_valid}, 32'd1);
        chk_ch("single_frame", 16'hA5F3);
        chk("single_count", fv_count, 32'd1);

        // Back-to-back frames, en gaps inside slot 2 of the second frame.
        send(16'hA5F3, 16, 1'b1);
        chk_ch("b2b_first", 16'hA5F3);
        send(16'h1248, 10, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        chk_ch("b2b_hold", 16'hA5F3);
        send(16'h1248 << 10, 6, 1'b0);
        chk_ch("b2b_second", 16'h1248);
        chk("b2b_count", fv_count, 32'd3);
        chk("b2b_spacing", strobe_q[strobe_q.size()-1] - strobe_q[strobe_q.size()-2], 32'd16);

        // Early sync at slot 1 bit 2, realign onto C,3,6,9.
        fv0 = fv_count;
        send(16'hFFFF, 6, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        chk("early_err", {30'd0, sync_err, frame_valid}, 32'd2);
        send(16'hC369 << 1, 15, 1'b0);
        chk_ch("early_realign", 16'hC369);
        chk("early_count", fv_count - fv0, 32'd1);

        // Missing sync at the next frame start.
        tick(1'b1, 1'b0, 1'b1);
        chk("missing_err", {30'd0, sync_err, locked}, 32'd2);
        send(16'hFFFF, 8, 1'b0);
        chk_ch("missing_hold", 16'hC369);

        // Reset mid-frame (slot 2), then one clean frame.
        send(16'h1234, 9, 1'b1);
        #2 rst = 1'b1;
        #1 chk("async_rst", {11'd0, ch0, ch1, ch2, ch3, frame_valid, locked, sync_err, slot}, 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        fv0 = fv_count;
        send(16'h7777, 16, 1'b1);
        chk_ch("post_rst_frame", 16'h7777);
        chk("post_rst_count", fv_count - fv0, 32'd1);

        // Randomized frames with en gaps, corrupted markers and stray idle bits.
        err0 = err_count;
        for (int f = 0; f < 100; f++) begin
            data = 16'($urandom);
            if ($urandom_range(0, 9) == 0) tick(1'($urandom), 1'b0, 1'b1);
            for (int i = 0; i < 16; i++) begin
                while ($urandom_range(0, 7) == 0) tick(1'($urandom), 1'($urandom), 1'b0);
                s = (i == 0);
                if ($urandom_range(0, 39) == 0) s = ~s;
                tick(data[15-i], s, 1'b1);
            end
        end
        tick(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive end of the team's 4:1 channel-select path. A serial stream carries frames of four fixed-width slots (channel 0 first), each slot MSB first, with a `sync` marker on the first bit of every frame. The block aligns to `sync`, deserializes each slot, and presents all four channel words together with a one-cycle `frame_valid` strobe.

## Interface
- `WIDTH`, 8: bits per slot/channel word; legal range 2..16.
- `clk`  input  1  rising-edge clock; all state changes on this edge.
- `rst`  input  1  asynchronous reset, active-high.
- `en`  input  1  bit-enable; `din`/`sync` are sampled only on edges where `en`=1.
- `din`  input  1  serial data bit.
- `sync`  input  1  frame marker; 1 on the first bit (slot 0, MSB) of a frame.
- `ch0`..`ch3`  output  WIDTH each  last complete frame's channel words.
- `frame_valid`  output  1  one-cycle pulse: `ch0`..`ch3` have just been updated.
- `locked`  output  1  1 while in RUN.
- `sync_err`  output  1  one-cycle pulse on a framing error.
- `slot`  output  2  slot index of the next bit expected; 0 while in HUNT.

## Operation
- Reset (asynchronous, any time, including mid-frame): state HUNT; bit counter, `slot`, shift register and shadow registers cleared; `ch0`..`ch3`=0; `frame_valid`=0; `locked`=0; `sync_err`=0. No partial frame survives reset.
- Edges with `en`=0: counters, shift register and state hold; `frame_valid` and `sync_err` are 0 on the following cycle.
- HUNT: sampled bits with `sync`=0 are discarded. A sample with `sync`=1 is taken as bit 0 of slot 0. It is shifted in, and the state moves to RUN with bit count 1.
- RUN, every sampled bit: shift in MSB first and increment the bit counter. When the counter reaches WIDTH, the completed word goes to shadow register `slot`, the counter returns to 0, and `slot` increments modulo 4.
- Frame completion: the sample that completes slot 3 loads `ch0`..`ch2` from the shadows and `ch3` from the just-completed word, all on the same edge, and asserts `frame_valid`. `ch*` hold between frames.
- Framing rules in RUN:
  - Expected frame start (slot 0, bit 0) with `sync`=1: normal.
  - Expected frame start with `sync`=0: pulse `sync_err`, discard the bit, go to HUNT.
  - `sync`=1 at any other position: pulse `sync_err`, discard the partial frame, and realign with this bit as slot 0 bit 0. The state stays RUN.
- In both error cases `ch*` are not updated and `frame_valid` is not asserted.
- `sync_err` and `frame_valid` are never 1 in the same cycle.

## Timing
- All outputs are registered and change only on `clk` rising or on `rst` assertion.
- Latency: `ch*` and `frame_valid` are valid in the cycle immediately after the edge that samples the last bit of slot 3. With `en` held at 1, that is 4·WIDTH edges after the `sync` bit.
- `frame_valid` and `sync_err` are high for exactly one clock.
- `locked` rises after the edge that samples the first `sync` in HUNT. It falls after the edge that detects a missing `sync`.
- `slot` and the bit counter wrap 3→0 and WIDTH−1→0 without gaps. Back-to-back frames need no idle bits.
- Throughput is at most one frame per 4·WIDTH enabled edges.

## Test plan
All scenarios use WIDTH=4, `en`=1 unless stated.
- Reset/idle: assert `rst` mid-simulation, async with no clock edge → all outputs 0 immediately. Hold `rst` low with `din`=1, `sync`=0 for 20 cycles → `locked`=0 and no strobes.
- Single frame: `sync` on bit 0, bits 1010 0101 1111 0011 → one `frame_valid` after the 16th edge, with `ch0`=A, `ch1`=5, `ch2`=F, `ch3`=3. `locked`=1 from edge 1.
- Back-to-back frames with `en` gaps: two frames (A,5,F,3) then (1,2,4,8), with `en` held 0 for 3 cycles inside slot 2 of frame 2 → two strobes, 16 enabled edges apart. The final `ch*` are 1,2,4,8, and the first frame's values hold between the strobes.
- Early `sync`: `sync` reasserted at slot 1 bit 2 → `sync_err` one cycle, no `frame_valid`, and realignment. The following 16 bits (C,3,6,9) produce `ch*`=C,3,6,9.
- Missing `sync`: after a good frame, the next frame start arrives with `sync`=0 → `sync_err` pulse, `locked`=0, and `ch*` retain the previous frame's values until a new `sync`.
- Reset mid-frame: assert `rst` at slot 2, then release and send a full frame (7,7,7,7) → only that frame is reported, with `ch*`=7,7,7,7.
